// File: rtl/cla_pkg.sv
// Shared defaults, per-stage payload and helpers for the pipelined CLA adder.
package cla_pkg;

   localparam int CLA_WIDTH = 32;
   localparam int CLA_BLOCK = 4;

   typedef struct packed {
      logic valid;
      logic carry;
      logic sub;
      logic sat;
   } stage_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/cla_block.sv
// One BLOCK-bit carry-lookahead group: every internal carry is a flat
// generate/propagate sum-of-products of ci, never a ripple chain.
module cla_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co,
   output logic             gg,
   output logic             pg
);

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      logic acc;
      logic term;
      c    = '0;
      gg   = 1'b0;
      pg   = 1'b1;
      c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         acc = ci;
         for (int j = 0; j <= i; j++) acc = acc & p[j];
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            acc = acc | term;
         end
         c[i+1] = acc;
      end
      for (int j = 0; j < BLOCK; j++) begin
         term = g[j];
         for (int k = j + 1; k < BLOCK; k++) term = term & p[k];
         gg = gg | term;
         pg = pg & p[j];
      end
   end

   assign s  = p ^ c[BLOCK-1:0];
   assign co = c[BLOCK];

endmodule

// File: rtl/cla_pipe_adder.sv
// Skewed pipelined CLA adder/subtractor, one lookahead group per stage.
// Define CLA_PIPE_SAT_EN to add the per-beat saturation input `sat`.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int BLOCK = CLA_BLOCK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
`ifdef CLA_PIPE_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / BLOCK;
   localparam int LAST   = STAGES - 1;

   if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a positive multiple of BLOCK");
   end

   // Stage k reads p*[k]: the live inputs for k=0, stage k-1's register otherwise.
   logic [STAGES-1:0][WIDTH-1:0] pa, pb, ps;
   stage_t [STAGES-1:0]          pst;

   logic [STAGES-1:0][WIDTH-1:0] a_d, a_q, b_d, b_q, s_d, s_q;
   stage_t [STAGES-1:0]          st_d, st_q;
   logic                         ovf_d, ovf_q;

   logic [STAGES-1:0][BLOCK-1:0] blk_s;
   logic [STAGES-1:0]            blk_co, blk_g, blk_p;

   logic adv;
   logic msb_cin;

   assign adv       = out_ready | ~st_q[LAST].valid;
   assign in_ready  = adv;
   assign out_valid = st_q[LAST].valid;
   assign sum       = s_q[LAST];
   assign cout      = st_q[LAST].carry;
   assign ovf       = ovf_q;

   always_comb begin
      pa     = '0;
      pb     = '0;
      ps     = '0;
      pst    = '0;
      pa[0]  = a;
      pb[0]  = sub ? ~b : b;
      pst[0].valid = in_valid;
      pst[0].carry = sub | cin;
      pst[0].sub   = sub;
`ifdef CLA_PIPE_SAT_EN
      pst[0].sat   = sat;
`endif
      for (int k = 1; k < STAGES; k++) begin
         pa[k]  = a_q[k-1];
         pb[k]  = b_q[k-1];
         ps[k]  = s_q[k-1];
         pst[k] = st_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cla_block #(.BLOCK(BLOCK)) u_blk (
         .a  (pa[k][k*BLOCK +: BLOCK]),
         .b  (pb[k][k*BLOCK +: BLOCK]),
         .ci (pst[k].carry),
         .s  (blk_s[k]),
         .co (blk_co[k]),
         .gg (blk_g[k]),
         .pg (blk_p[k])
      );
   end

   // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
   assign msb_cin = blk_s[LAST][BLOCK-1] ^ pa[LAST][WIDTH-1] ^ pb[LAST][WIDTH-1];

   always_comb begin
      a_d  = pa;
      b_d  = pb;
      s_d  = ps;
      st_d = pst;
      for (int k = 0; k < STAGES; k++) begin
         s_d[k][k*BLOCK +: BLOCK] = blk_s[k];
         st_d[k].carry            = blk_co[k];
      end
      ovf_d = msb_cin ^ blk_co[LAST];
`ifdef CLA_PIPE_SAT_EN
      // On overflow both operand MSBs agree, so A's MSB gives the direction.
      if (pst[LAST].sat && ovf_d)
         s_d[LAST] = pa[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         st_q  <= '0;
         ovf_q <= 1'b0;
      end else if (adv) begin
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
         st_q  <= st_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=32, BLOCK=4, 8 stages).
module tb_cla_pipe_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        cin, sub;
`ifdef CLA_PIPE_SAT_EN
   logic        sat;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout, ovf;

   cla_pipe_adder #(.WIDTH(32), .BLOCK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
`ifdef CLA_PIPE_SAT_EN
      .sat       (sat),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: a result transfers on the next edge when valid & ready at negedge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got sum %h with empty scoreboard", sum);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sum", sum, mon_e.s);
            chk("cout", {31'b0, cout}, {31'b0, mon_e.c});
            chk("ovf", {31'b0, ovf}, {31'b0, mon_e.o});
            if (mon_e.cyc >= 0) chk("latency", cyc, mon_e.cyc);
         end
      end
   end

   // Called right after a posedge; returns right after the accepting posedge.
   task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                       input logic isub, input logic isat, input logic [31:0] es,
                       input logic ec, input logic eo, input bit lat);
      int   n;
      exp_t e;
      in_valid = 1'b1;
      a = ia; b = ib; cin = icin; sub = isub;
`ifdef CLA_PIPE_SAT_EN
      sat = isat;
`else
      if (isat) $display("note: sat request ignored in this build");
`endif
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready stuck at %b, required 1", in_ready);
      end else begin
         e.s = es; e.c = ec; e.o = eo;
         e.cyc = lat ? cyc + 8 : -1;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
`ifdef CLA_PIPE_SAT_EN
      sat = 1'b0;
`endif
      #12;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", {31'b0, cout}, 0);
      chk("rst_ovf", {31'b0, ovf}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      @(posedge clk);
      #1;

      // Directed corner cases, each draining alone.
      send(32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_0000, 1, 0, 1);
      drain();
      send(32'h8000_0000, 32'h0000_0001, 0, 1, 0, 32'h7FFF_FFFF, 1, 1, 1);
      drain();
`ifdef CLA_PIPE_SAT_EN
      send(32'h8000_0000, 32'h0000_0001, 0, 1, 1, 32'h8000_0000, 1, 1, 1);
      send(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h7FFF_FFFF, 0, 1, 1);
      drain();
`endif
      send(32'h7FFF_FFFF, 32'h0000_0000, 1, 0, 0, 32'h8000_0000, 0, 1, 1);
      drain();

      // Back-to-back stream: latency 8 on every beat implies one per cycle.
      send(32'h0000_0000, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 0, 0, 1);
      send(32'h0000_0000, 32'h0000_0000, 1, 0, 0, 32'h0000_0001, 0, 0, 1);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFE, 1, 0, 1);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 32'hFFFF_FFFF, 1, 0, 1);
      send(32'h8000_0000, 32'h8000_0000, 0, 0, 0, 32'h0000_0000, 1, 1, 1);
      send(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h8000_0000, 0, 1, 1);
      send(32'h1234_5678, 32'h8765_4321, 0, 0, 0, 32'h9999_9999, 0, 0, 1);
      send(32'h0000_000F, 32'h0000_0001, 0, 0, 0, 32'h0000_0010, 0, 0, 1);
      send(32'h0000_00FF, 32'h0000_0001, 0, 0, 0, 32'h0000_0100, 0, 0, 1);
      send(32'h0FFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h1000_0000, 0, 0, 1);
      send(32'h0000_0005, 32'h0000_0003, 0, 1, 0, 32'h0000_0002, 1, 0, 1);
      send(32'h0000_0003, 32'h0000_0005, 0, 1, 0, 32'hFFFF_FFFE, 0, 0, 1);
      send(32'h0000_0000, 32'h0000_0000, 0, 1, 0, 32'h0000_0000, 1, 0, 1);
      send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 32'h8000_0000, 0, 1, 1);
      send(32'h0000_0010, 32'h0000_0001, 1, 1, 0, 32'h0000_000F, 1, 0, 1);
      send(32'hAAAA_AAAA, 32'h5555_5555, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 1);
      send(32'hAAAA_AAAA, 32'h5555_5555, 1, 0, 0, 32'h0000_0000, 1, 0, 1);
      send(32'h0001_0000, 32'h0000_FFFF, 1, 0, 0, 32'h0002_0000, 0, 0, 1);
      send(32'hDEAD_BEEF, 32'h0000_0000, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 1);
      send(32'h8000_0000, 32'h8000_0000, 0, 1, 0, 32'h0000_0000, 1, 0, 1);
      drain();

      // Backpressure: consumer stalls 5 cycles once the first result shows.
      fork
         begin
            send(32'h1111_1111, 32'h1111_1111, 0, 0, 0, 32'h2222_2222, 0, 0, 0);
            send(32'h4000_0000, 32'h4000_0000, 0, 0, 0, 32'h8000_0000, 0, 1, 0);
            send(32'h0000_0001, 32'h0000_0002, 0, 0, 0, 32'h0000_0003, 0, 0, 0);
            send(32'h0000_0001, 32'h0000_0002, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
            send(32'hF000_0000, 32'h1000_0000, 0, 0, 0, 32'h0000_0000, 1, 0, 0);
            send(32'h0000_0100, 32'h0000_0100, 1, 0, 0, 32'h0000_0201, 0, 0, 0);
         end
         begin
            int          n;
            logic [31:0] held;
            n = 0;
            do begin
               @(posedge clk);
               #1;
               n++;
            end while (!out_valid && n < 100);
            chk("stall_first_valid", {31'b0, out_valid}, 1);
            out_ready = 1'b0;
            held = sum;
            repeat (5) begin
               @(negedge clk);
               chk("stall_in_ready", {31'b0, in_ready}, 0);
               chk("stall_sum_hold", sum, held);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with beats in flight: all are discarded.
      send(32'h0000_0001, 32'h0000_0001, 0, 0, 0, 32'h0000_0002, 0, 0, 1);
      send(32'h0000_0002, 32'h0000_0002, 0, 0, 0, 32'h0000_0004, 0, 0, 1);
      send(32'h0000_0003, 32'h0000_0003, 0, 0, 0, 32'h0000_0006, 0, 0, 1);
      send(32'h0000_0004, 32'h0000_0004, 0, 0, 0, 32'h0000_0008, 0, 0, 1);
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!out_valid && n < 100);
         chk("pre_rst_valid", {31'b0, out_valid}, 1);
      end
      #2;
      rst = 1'b1;
      #1;
      chk("rst_flush_valid", {31'b0, out_valid}, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 1);
      @(posedge clk);
      #1;
      send(32'h0000_0002, 32'h0000_0003, 0, 0, 0, 32'h0000_0005, 0, 0, 1);
      drain();
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
